// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Includes the half-subtractor helper used to build the full-subtractor cell.
package serial_sub_pkg;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    typedef struct packed {
        logic diff;
        logic borrow;
    } half_sub_t;

    function automatic half_sub_t half_sub(input logic a, input logic b);
        half_sub_t r;
        r.diff   = a ^ b;
        r.borrow = ~a & b;
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational full-subtractor cell: two half-subtractor stages whose
// borrows are ORed together.
module full_subtractor
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    half_sub_t stage1_s;
    half_sub_t stage2_s;

    // Chain the two half-subtractor stages.
    always_comb begin
        stage1_s = half_sub(a, b);
        stage2_s = half_sub(stage1_s.diff, bin);
        diff     = stage2_s.diff;
        bout     = stage1_s.borrow | stage2_s.borrow;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds the out_overflow port.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             out_overflow,
`endif
    output logic             out_borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sub_state_e       state_r;
    sub_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic             borrow_r;
    logic [WIDTH-1:0] diff_r;
    logic             dborrow_r;
    logic             fs_diff_s;
    logic             fs_bout_s;
    logic             last_bit_s;
    logic             accept_s;

    full_subtractor u_fs (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (borrow_r),
        .diff (fs_diff_s),
        .bout (fs_bout_s)
    );

    // Handshake qualifiers and the result word with the new bit at the MSB.
    always_comb begin
        accept_s   = (state_r == IDLE) && in_valid;
        last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
        res_nxt_s  = res_r >> 1'b1;
        res_nxt_s[WIDTH-1] = fs_diff_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            RUN:     in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Serial datapath; the visible result only changes on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            res_r     <= '0;
            borrow_r  <= 1'b0;
            diff_r    <= '0;
            dborrow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        borrow_r <= 1'b0;
                        cnt_r    <= '0;
                    end
                end
                RUN: begin
                    a_r      <= a_r >> 1'b1;
                    b_r      <= b_r >> 1'b1;
                    res_r    <= res_nxt_s;
                    borrow_r <= fs_bout_s;
                    cnt_r    <= cnt_r + CNT_W'(1'b1);
                    if (last_bit_s) begin
                        diff_r    <= res_nxt_s;
                        dborrow_r <= fs_bout_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign out_diff   = diff_r;
    assign out_borrow = dborrow_r;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Signed overflow: operand signs differ and the result sign departs from a.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_msb_r <= in_a[WIDTH-1];
                b_msb_r <= in_b[WIDTH-1];
            end
            if ((state_r == RUN) && last_bit_s) begin
                ovf_r <= (a_msb_r != b_msb_r) && (fs_diff_s != a_msb_r);
            end
        end
    end

    assign out_overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances),
// compared against plain-arithmetic reference functions.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_borrow;
    logic [7:0] in_a, in_b, out_diff;
    logic       ovf;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_borrow1;
    logic [0:0] in_a1, in_b1, out_diff1;
    logic       ovf1;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_diff(out_diff),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .out_overflow(ovf),
`endif
        .out_borrow(out_borrow)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_diff(out_diff1),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .out_overflow(ovf1),
`endif
        .out_borrow(out_borrow1)
    );

`ifndef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = (int'(a) - int'(b) + 256) % 256;
        return t[7:0];
    endfunction

    function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
        return int'(a) < int'(b);
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, r;
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic bo, output logic ov,
                          output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        tick();
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        d  = out_diff;
        bo = out_borrow;
        ov = ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total += 6;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_diff !== 8'h00) begin bad++; $display("FAIL reset_out_diff got=%h exp=00", out_diff); end
        if (out_borrow !== 1'b0) begin bad++; $display("FAIL reset_out_borrow got=%b exp=0", out_borrow); end
        if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_w1_in_ready got=%b exp=1", in_ready1); end
        if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_w1_out_valid got=%b exp=0", out_valid1); end
    endtask

    task automatic test_directed;
        logic [7:0] va [3] = '{8'd100, 8'h00, 8'hA5};
        logic [7:0] vb [3] = '{8'd37,  8'h01, 8'hA5};
        logic [7:0] ed [3] = '{8'h3F,  8'hFF, 8'h00};
        logic       eb [3] = '{1'b0,   1'b1,  1'b0};
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], d, bo, ov, lat);
            total += 3;
            if (d !== ed[i]) begin bad++; $display("FAIL directed_diff[%0d] got=%h exp=%h", i, d, ed[i]); end
            if (bo !== eb[i]) begin bad++; $display("FAIL directed_borrow[%0d] got=%b exp=%b", i, bo, eb[i]); end
            if (lat != 8) begin bad++; $display("FAIL directed_latency[%0d] got=%0d exp=8", i, lat); end
            release_out();
            total += 2;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL directed_idle_ready[%0d] got=%b exp=1", i, in_ready); end
            if (out_valid !== 1'b0) begin bad++; $display("FAIL directed_idle_valid[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        run_op(8'h10, 8'h01, d, bo, ov, lat);
        total++;
        if (d !== 8'h0F) begin bad++; $display("FAIL bp_first_diff got=%h exp=0f", d); end
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
            if (out_diff !== 8'h0F) begin bad++; $display("FAIL bp_hold_diff[%0d] got=%h exp=0f", i, out_diff); end
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0", i, in_ready); end
        end
        release_out();
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b exp=0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        total += 3;
        if (out_diff !== 8'hFF) begin bad++; $display("FAIL bp_second_diff got=%h exp=ff", out_diff); end
        if (out_borrow !== 1'b0) begin bad++; $display("FAIL bp_second_borrow got=%b exp=0", out_borrow); end
        if (lat != 8) begin bad++; $display("FAIL bp_second_latency got=%0d exp=8", lat); end
        release_out();
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        in_valid = 1'b1;
        in_a = 8'hC8;
        in_b = 8'h37;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 4;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        if (out_diff !== 8'h00) begin bad++; $display("FAIL midrst_out_diff got=%h exp=00", out_diff); end
        if (out_borrow !== 1'b0) begin bad++; $display("FAIL midrst_out_borrow got=%b exp=0", out_borrow); end
        run_op(8'h10, 8'h01, d, bo, ov, lat);
        total += 2;
        if (d !== 8'h0F) begin bad++; $display("FAIL midrst_after_diff got=%h exp=0f", d); end
        if (bo !== 1'b0) begin bad++; $display("FAIL midrst_after_borrow got=%b exp=0", bo); end
        release_out();
    endtask

    task automatic test_random;
        logic [7:0] a, b, d;
        logic       bo, ov;
        int         lat;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(a, b, d, bo, ov, lat);
            total += 3;
            if (d !== ref_diff(a, b)) begin bad++; $display("FAIL rand_diff a=%h b=%h got=%h exp=%h", a, b, d, ref_diff(a, b)); end
            if (bo !== ref_borrow(a, b)) begin bad++; $display("FAIL rand_borrow a=%h b=%h got=%b exp=%b", a, b, bo, ref_borrow(a, b)); end
            if (lat != 8) begin bad++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=8", a, b, lat); end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            total++;
            if (ov !== ref_ovf(a, b)) begin bad++; $display("FAIL rand_ovf a=%h b=%h got=%b exp=%b", a, b, ov, ref_ovf(a, b)); end
`endif
            repeat ($urandom_range(0, 3)) tick();
            total++;
            if (out_diff !== d) begin bad++; $display("FAIL rand_hold a=%h b=%h got=%h exp=%h", a, b, out_diff, d); end
            release_out();
        end
    endtask

    task automatic test_width1;
        logic [0:0] a, b, e;
        int         t, lat;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0 || i == 2) ? 1'b0 : 1'b1;
            b = (i < 2) ? 1'b1 : 1'b0;
            t = int'(a) - int'(b);
            e = t[0];
            in_valid1 = 1'b1;
            in_a1 = a;
            in_b1 = b;
            tick();
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 10) begin
                tick();
                lat++;
            end
            total += 3;
            if (out_diff1 !== e) begin bad++; $display("FAIL w1_diff a=%b b=%b got=%b exp=%b", a, b, out_diff1, e); end
            if (out_borrow1 !== (t < 0)) begin bad++; $display("FAIL w1_borrow a=%b b=%b got=%b exp=%b", a, b, out_borrow1, t < 0); end
            if (lat != 1) begin bad++; $display("FAIL w1_latency a=%b b=%b got=%0d exp=1", a, b, lat); end
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end
    endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    task automatic test_overflow;
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        run_op(8'h80, 8'h01, d, bo, ov, lat);
        total += 2;
        if (d !== 8'h7F) begin bad++; $display("FAIL ovf_case1_diff got=%h exp=7f", d); end
        if (ov !== 1'b1) begin bad++; $display("FAIL ovf_case1_flag got=%b exp=1", ov); end
        release_out();
        run_op(8'h7F, 8'h01, d, bo, ov, lat);
        total += 2;
        if (d !== 8'h7E) begin bad++; $display("FAIL ovf_case2_diff got=%h exp=7e", d); end
        if (ov !== 1'b0) begin bad++; $display("FAIL ovf_case2_flag got=%b exp=0", ov); end
        release_out();
    endtask
`endif

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = 8'h00;
        in_b       = 8'h00;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_a1      = 1'b0;
        in_b1      = 1'b0;
        out_ready1 = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_width1();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        test_overflow();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: accepts two WIDTH-bit operands over a valid/ready handshake and computes diff = a - b, one bit per clock, LSB first.
- Uses a borrow flip-flop and one full-subtractor cell built from two half-subtractor stages.
- Serves as the subtraction counterpart to the combinational adder cells in the arithmetic step series.
- Trades latency (WIDTH cycles) for one-bit datapath area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  minuend.
- in_b  input  WIDTH  subtrahend.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_diff  output  WIDTH  (in_a - in_b) mod 2^WIDTH.
- out_borrow  output  1  final borrow; 1 iff in_a < in_b (unsigned).

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - State goes to IDLE; the bit counter, operand and result shift registers, and borrow are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, out_diff=0, out_borrow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at a rising edge: latch in_a and in_b into shift registers, clear borrow and counter, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle:
    - Take a0 and b0 (register LSBs) and current borrow bin.
    - d = a0 ^ b0 ^ bin.
    - bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
    - Shift d into the result register from the MSB end; shift both operand registers right; borrow <= bout; counter++.
  - When the counter reaches WIDTH-1 and that bit has been processed, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_diff and out_borrow are stable and hold while out_ready=0.
  - On out_ready=1 at a rising edge: go to IDLE. The next operand is accepted no earlier than the following edge; there is no same-cycle turnaround.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- out_diff and out_borrow retain their last values in IDLE and RUN; only the valid flags qualify them.
- in_valid outside IDLE is ignored; operands are not required to remain stable after acceptance.
- rst mid-RUN or in DONE: the partial result is discarded and all reset values apply on the next edge; rst has priority over every handshake.
- WIDTH=1: RUN lasts one cycle.
- Counter width is clog2(WIDTH+1).

Optional Feature:
- Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port out_overflow (1 bit) giving two's-complement overflow: (a_msb != b_msb) && (diff_msb != a_msb).
  - a_msb and b_msb are captured at accept.
  - Valid under the same rules as out_diff; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - State typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant SERIAL_SUB_DEFAULT_WIDTH=8.
- Sub-module full_subtractor (combinational; a, b, bin -> diff, bout), composed of two half-subtractor stages (diff=a^b, borrow=~a&b) plus an OR of the borrows.
- Top holds the FSM, counter, shift registers and borrow flop.

Test Plan:
- WIDTH=8: in_a=100, in_b=37 -> out_diff=63 (8'h3F), out_borrow=0; out_valid rises exactly 8 cycles after the accept edge.
- in_a=8'h00, in_b=8'h01 -> out_diff=8'hFF, out_borrow=1. Also in_a=8'hA5, in_b=8'hA5 -> out_diff=8'h00, out_borrow=0.
- Backpressure:
  - Stimulus: in_a=8'h10, in_b=8'h01; hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with in_a=8'hFF, in_b=8'h00 throughout that window.
  - Required: out_valid stays 1, out_diff stays 8'h0F, in_ready stays 0, the new operands are not accepted.
  - After out_ready=1: IDLE on the next edge, in_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle during RUN bit 3 of in_a=8'hC8, in_b=8'h37.
  - Required: next cycle in_ready=1, out_valid=0, out_diff=0, out_borrow=0.
  - A following in_a=8'h10, in_b=8'h01 yields 8'h0F, borrow 0.
- WIDTH=1 instance: in_a=0, in_b=1 -> out_diff=1, out_borrow=1, out_valid 1 cycle after accept.
- With SERIAL_SUB_SIGNED_OVF_EN:
  - 8'h80 - 8'h01 -> out_diff=8'h7F, out_overflow=1.
  - 8'h7F - 8'h01 -> out_diff=8'h7E, out_overflow=0.
